// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter and fetch sequencer with start/done handshake
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, start_addr     launch pulse and entry address (IDLE only)
//   inst                  instruction from ROM for the current iptr
//   stall                 freezes iptr and counter in RUN
//   flag_eq/lt/gt         compare flags read in the branch's own cycle
//   iptr                  instruction address to the ROM
//   inst_valid            inst executes this cycle
//   done                  one-cycle pulse after a done instruction retires
//   busy                  high in RUN
//   inst_count            instructions retired since the last start (saturating)
module fetch_ctrl #(
  parameter int AW = 9,
  parameter int IW = 20,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [IW-1:0] inst,
  input  logic          stall,
  input  logic          flag_eq,
  input  logic          flag_lt,
  input  logic          flag_gt,
  output logic [AW-1:0] iptr,
  output logic          inst_valid,
  output logic          done,
  output logic          busy,
  output logic [CW-1:0] inst_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state;
  logic [4:0] op;
  logic [AW-1:0] off;
  logic taken, is_done;
  assign op = inst[IW-1 -: 5];
  // sign-extend (or truncate) the 15-bit offset to the address width
  assign off = AW'($signed(inst[14:0]));
  assign taken = (op == 5'b00111 && flag_eq) || (op == 5'b01000 && flag_lt) ||
                 (op == 5'b01001 && flag_gt) || op == 5'b01010;
  assign is_done = op == 5'b01110;
  assign busy = state == RUN;
  assign inst_valid = busy && !stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iptr <= '0;
      inst_count <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          iptr <= start_addr;
          inst_count <= '0;
          state <= RUN;
        end
        RUN: if (!stall) begin
          inst_count <= &inst_count ? inst_count : inst_count + CW'(1);
          if (is_done) begin
            done <= 1'b1;
            state <= HALT;
          end else begin
            iptr <= iptr + (taken ? off : AW'(1));
          end
        end
        HALT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic flag_eq = 1'b0, flag_lt = 1'b0, flag_gt = 1'b0;
  logic [8:0] start_addr = '0, iptr;
  logic [19:0] inst;
  logic inst_valid, done, busy;
  logic [15:0] inst_count;
  int checks = 0, errors = 0;
  localparam logic [19:0] ADD = {5'b00001, 15'd0};
  localparam logic [19:0] DN = {5'b01110, 15'd0};
  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .inst(inst),
    .stall(stall), .flag_eq(flag_eq), .flag_lt(flag_lt), .flag_gt(flag_gt),
    .iptr(iptr), .inst_valid(inst_valid), .done(done), .busy(busy), .inst_count(inst_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [8:0] a);
    start = 1'b1;
    start_addr = a;
    step();
    start = 1'b0;
  endtask
  task automatic finish_prog();
    inst = DN;
    step();
    step();
    inst = ADD;
  endtask
  initial begin
    inst = ADD;
    repeat (2) step();
    chk("rst_iptr", iptr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_count", inst_count, 0);
    rst_n = 1'b1;
    step();
    chk("idle_hold", iptr, 0);
    launch(9'd1);
    chk("seq_iptr1", iptr, 1);
    chk("seq_busy", busy, 1);
    chk("seq_valid", inst_valid, 1);
    chk("seq_count0", inst_count, 0);
    step();
    chk("seq_iptr2", iptr, 2);
    step();
    chk("seq_iptr3", iptr, 3);
    step();
    chk("seq_iptr4", iptr, 4);
    chk("seq_count3", inst_count, 3);
    finish_prog();
    launch(9'd16);
    inst = {5'b01000, 15'h7ff2};
    flag_lt = 1'b1;
    step();
    chk("bl_taken", iptr, 2);
    flag_lt = 1'b0;
    finish_prog();
    launch(9'd16);
    inst = {5'b01000, 15'h7ff2};
    flag_eq = 1'b1;
    flag_gt = 1'b1;
    step();
    chk("bl_not_taken", iptr, 17);
    flag_eq = 1'b0;
    flag_gt = 1'b0;
    finish_prog();
    launch(9'd4);
    inst = {5'b00111, 15'd4};
    flag_eq = 1'b1;
    step();
    chk("be_taken", iptr, 8);
    flag_eq = 1'b0;
    inst = {5'b01001, 15'd4};
    step();
    chk("bg_not_taken", iptr, 9);
    finish_prog();
    launch(9'd5);
    inst = {5'b01010, 15'h7ffd};
    step();
    chk("ba_back", iptr, 2);
    inst = {5'b01010, 15'd0};
    step();
    chk("ba_self", iptr, 2);
    chk("ba_count", inst_count, 2);
    finish_prog();
    launch(9'd511);
    inst = ADD;
    step();
    chk("wrap_iptr", iptr, 0);
    chk("wrap_count", inst_count, 1);
    inst = DN;
    step();
    chk("done_pulse", done, 1);
    chk("done_count", inst_count, 2);
    chk("done_busy", busy, 0);
    chk("done_valid", inst_valid, 0);
    chk("done_iptr", iptr, 0);
    start = 1'b1;
    start_addr = 9'd77;
    step();
    start = 1'b0;
    inst = ADD;
    chk("done_once", done, 0);
    chk("halt_start_ign", iptr, 0);
    chk("halt_to_idle", busy, 0);
    chk("count_readout", inst_count, 2);
    launch(9'd10);
    stall = 1'b1;
    inst = DN;
    #1;
    chk("stall_valid", inst_valid, 0);
    repeat (3) step();
    chk("stall_iptr", iptr, 10);
    chk("stall_count", inst_count, 0);
    chk("stall_done", done, 0);
    chk("stall_busy", busy, 1);
    stall = 1'b0;
    inst = ADD;
    step();
    chk("unstall_iptr", iptr, 11);
    chk("unstall_count", inst_count, 1);
    finish_prog();
    launch(9'd39);
    step();
    chk("pre_rst_iptr", iptr, 40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_iptr", iptr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", inst_count, 0);
    chk("arst_valid", inst_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(9'd20);
    start = 1'b1;
    start_addr = 9'd99;
    step();
    start = 1'b0;
    chk("run_start_ign", iptr, 21);
    finish_prog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
